// File: rtl/stream_pixel_packer.sv
// rtl/stream_pixel_packer.sv - packs pixels LSB-first into OUT_W-bit stream words; optional STREAM_PIXEL_PACKER_SWAP_RB_EN swaps channel 0 and CHANNELS-1
module stream_pixel_packer #(
   parameter int CHAN_W   = 8,
   parameter int CHANNELS = 3,
   parameter int OUT_W    = 32
) (
   input  logic                       aclk,
   input  logic                       reset,
   input  logic [CHANNELS*CHAN_W-1:0] in_pixel,
   input  logic                       in_valid,
   input  logic                       in_sof,
   input  logic                       in_eol,
   output logic                       in_ready,
   output logic [OUT_W-1:0]           out_stream_tdata,
   output logic [OUT_W/8-1:0]         out_stream_tkeep,
   output logic                       out_stream_tlast,
   output logic                       out_stream_tuser,
   output logic                       out_stream_tvalid,
   input  logic                       out_stream_tready
);

   localparam int BPP = CHANNELS * CHAN_W;
   localparam int AW  = OUT_W + BPP;
   localparam int FW  = $clog2(AW + 1);
   localparam int KW  = OUT_W / 8;

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   state_t         state;
   logic [AW-1:0]  acc;
   logic [FW-1:0]  fill;
   logic           pend_user;

   logic [BPP-1:0] pix;
   logic           slot_free;
   logic           accept;
   logic           pend_next;
   logic           emit;
   logic [AW-1:0]  acc_base, acc_sum, acc_rem;
   logic [FW-1:0]  fill_base, fill_sum, fill_rem;
   logic [KW-1:0]  keep_flush;

`ifdef STREAM_PIXEL_PACKER_SWAP_RB_EN
   always_comb begin
      pix = in_pixel;
      pix[CHAN_W-1:0]      = in_pixel[BPP-1 -: CHAN_W];
      pix[BPP-1 -: CHAN_W] = in_pixel[CHAN_W-1:0];
   end
`else
   assign pix = in_pixel;
`endif

   assign slot_free = !out_stream_tvalid || out_stream_tready;
   assign in_ready  = !reset && (state == S_RUN) && slot_free;
   assign accept    = in_valid && in_ready;
   assign pend_next = in_sof || pend_user;

   // A start-of-frame pixel discards any residue left by a malformed previous line.
   always_comb begin
      acc_base  = in_sof ? '0 : acc;
      fill_base = in_sof ? '0 : fill;
      acc_sum   = acc_base | (AW'(pix) << fill_base);
      fill_sum  = fill_base + FW'(BPP);
      emit      = fill_sum >= FW'(OUT_W);
      acc_rem   = emit ? (acc_sum >> OUT_W) : acc_sum;
      fill_rem  = emit ? (fill_sum - FW'(OUT_W)) : fill_sum;
   end

   always_comb begin
      keep_flush = '0;
      for (int i = 0; i < KW; i++) begin
         keep_flush[i] = fill > FW'(8 * i);
      end
   end

   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         state             <= S_RUN;
         acc               <= '0;
         fill              <= '0;
         pend_user         <= 1'b0;
         out_stream_tdata  <= '0;
         out_stream_tkeep  <= '0;
         out_stream_tlast  <= 1'b0;
         out_stream_tuser  <= 1'b0;
         out_stream_tvalid <= 1'b0;
      end else begin
         if (out_stream_tready) begin
            out_stream_tvalid <= 1'b0;
         end
         case (state)
            S_RUN: begin
               if (accept) begin
                  acc       <= acc_rem;
                  fill      <= fill_rem;
                  pend_user <= pend_next;
                  if (emit) begin
                     out_stream_tdata  <= acc_sum[OUT_W-1:0];
                     out_stream_tkeep  <= '1;
                     out_stream_tlast  <= in_eol && (fill_rem == '0);
                     out_stream_tuser  <= pend_next;
                     out_stream_tvalid <= 1'b1;
                     pend_user         <= 1'b0;
                  end
                  if (in_eol && (fill_rem != '0)) begin
                     state <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               // Bits above fill are always zero, so the partial word needs no masking.
               if (slot_free) begin
                  out_stream_tdata  <= acc[OUT_W-1:0];
                  out_stream_tkeep  <= keep_flush;
                  out_stream_tlast  <= 1'b1;
                  out_stream_tuser  <= pend_user;
                  out_stream_tvalid <= 1'b1;
                  pend_user         <= 1'b0;
                  acc               <= '0;
                  fill              <= '0;
                  state             <= S_RUN;
               end
            end
            default: state <= S_RUN;
         endcase
      end
   end

endmodule
